// File: rtl/data_mem_pipe.sv
// data_mem_pipe: byte-addressed big-endian data memory with fixed request-to-response latency
module data_mem_pipe #(
  parameter int MEM_DEPTH = 65536,
  parameter int LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        w_req_valid,
  output logic        w_req_ready,
  input  logic        w_write_op,
  input  logic [1:0]  w_size,
  input  logic        w_signed,
  input  logic [31:0] w_addr_32,
  input  logic [31:0] w_data_in_32,
  output logic        w_resp_valid,
  output logic [31:0] w_data_out_32,
  output logic        w_err
);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [7:0]  mem_q [MEM_DEPTH];
  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        op_q, sgn_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, din_q;
  logic        accept, go_resp;
  logic        e_op, e_sgn, e_err;
  logic [1:0]  e_size;
  logic [31:0] e_addr, e_din, ld;
  logic [2:0]  e_nb;
  logic [32:0] e_end;
  logic [AW-1:0] i0, i1, i2, i3;
  logic [7:0]  b;
  logic [15:0] h;
  assign accept  = w_req_valid && state_q == IDLE;
  assign go_resp = (accept && LATENCY == 1) || (state_q == WAIT && cnt_q == 3'(LATENCY - 1));
  // With LATENCY=1 the memory access happens on the accept edge, so use live inputs while idle
  assign e_op   = state_q == IDLE ? w_write_op   : op_q;
  assign e_size = state_q == IDLE ? w_size       : size_q;
  assign e_sgn  = state_q == IDLE ? w_signed     : sgn_q;
  assign e_addr = state_q == IDLE ? w_addr_32    : addr_q;
  assign e_din  = state_q == IDLE ? w_data_in_32 : din_q;
  assign e_nb   = e_size == 2'd0 ? 3'd1 : e_size == 2'd1 ? 3'd2 : 3'd4;
  assign e_end  = {1'b0, e_addr} + {30'd0, e_nb};
  assign e_err  = e_size == 2'd3 || (e_size == 2'd1 && e_addr[0]) ||
                  (e_size == 2'd2 && e_addr[1:0] != 2'd0) || e_end > 33'(MEM_DEPTH);
  assign i0 = e_addr[AW-1:0];
  assign i1 = i0 + AW'(1);
  assign i2 = i0 + AW'(2);
  assign i3 = i0 + AW'(3);
  assign b  = mem_q[i0];
  assign h  = {mem_q[i0], mem_q[i1]};
  assign ld = e_size == 2'd0 ? (e_sgn ? {{24{b[7]}}, b} : {24'd0, b}) :
              e_size == 2'd1 ? (e_sgn ? {{16{h[15]}}, h} : {16'd0, h}) :
              {mem_q[i0], mem_q[i1], mem_q[i2], mem_q[i3]};
  // Next-state: IDLE -> WAIT (or RESP when LATENCY=1) -> RESP -> IDLE
  always_comb begin
    state_d = go_resp ? RESP : accept ? WAIT : state_q == WAIT ? WAIT : IDLE;
    cnt_d   = accept ? 3'd1 : state_q == WAIT ? cnt_q + 3'd1 : 3'd0;
    data_d  = (go_resp && !e_op && !e_err) ? ld : 32'd0;
    err_d   = go_resp && e_err;
  end
  // Control and response registers; reset aborts any request in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
  // Capture the request so later input changes cannot disturb it
  always_ff @(posedge clock) begin
    if (accept) begin
      op_q   <= w_write_op;
      size_q <= w_size;
      sgn_q  <= w_signed;
      addr_q <= w_addr_32;
      din_q  <= w_data_in_32;
    end
  end
  // Big-endian store of the addressed bytes on the edge entering RESP; contents survive reset
  always_ff @(posedge clock) begin
    if (!reset && go_resp && e_op && !e_err) begin
      if (e_size == 2'd0) begin
        mem_q[i0] <= e_din[7:0];
      end else if (e_size == 2'd1) begin
        mem_q[i0] <= e_din[15:8];
        mem_q[i1] <= e_din[7:0];
      end else begin
        mem_q[i0] <= e_din[31:24];
        mem_q[i1] <= e_din[23:16];
        mem_q[i2] <= e_din[15:8];
        mem_q[i3] <= e_din[7:0];
      end
    end
  end
  assign w_req_ready   = state_q == IDLE;
  assign w_resp_valid  = state_q == RESP;
  assign w_data_out_32 = data_q;
  assign w_err         = err_q;
endmodule

// File: doc/data_mem_pipe.md
DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 65536, giving the number of bytes of storage, addresses 0..MEM_DEPTH-1.
REQ-002 The block SHALL have parameter LATENCY, default 2, legal range 1..7, giving the number of clock edges from request accept to response.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port w_req_valid, input, 1 bit: the request is present.
REQ-006 The block SHALL have port w_req_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port w_write_op, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port w_size, input, 2 bits: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-009 The block SHALL have port w_signed, input, 1 bit: 1 = sign-extend load data, 0 = zero-extend it.
REQ-010 The block SHALL have port w_addr_32, input, 32 bits: byte address.
REQ-011 The block SHALL have port w_data_in_32, input, 32 bits: store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-012 The block SHALL have port w_resp_valid, output, 1 bit: one-cycle pulse marking a completed request.
REQ-013 The block SHALL have port w_data_out_32, output, 32 bits: extended load data; 0 for stores and errors.
REQ-014 The block SHALL have port w_err, output, 1 bit: the completed request faulted; valid only while w_resp_valid=1.

Function
REQ-015 The block SHALL use big-endian byte ordering: the byte at addr is the most significant byte of a halfword or word.
REQ-016 The block SHALL implement a three-state FSM:
- IDLE: w_req_ready=1.
- WAIT: counts LATENCY-1 cycles; w_req_ready=0.
- RESP: w_resp_valid=1; w_req_ready=0.
REQ-017 The block SHALL accept a request on a rising edge where w_req_valid=1 and w_req_ready=1.
- On accept it SHALL capture w_write_op, w_size, w_signed, w_addr_32 and w_data_in_32.
- Later changes on those inputs SHALL have no effect on the request in flight.
REQ-018 On accept the block SHALL go to WAIT with the counter at 1, or straight to RESP when LATENCY=1.
REQ-019 In WAIT, the counter SHALL increment each edge, and the block SHALL go to RESP on the edge where the counter equals LATENCY-1.
REQ-020 w_resp_valid SHALL therefore be high for exactly the one cycle following the LATENCY-th rising edge after the accept edge.
REQ-021 From RESP, the block SHALL return to IDLE on the next edge. Minimum request spacing is LATENCY+1 cycles.
REQ-022 The block SHALL allow only one outstanding request; w_req_valid while not ready SHALL be ignored and not queued.
REQ-023 The block SHALL flag an error for any of the following:
- w_size=11;
- halfword with addr[0]=1;
- word with addr[1:0]!=00;
- addr+bytes-1 > MEM_DEPTH-1, computed without 32-bit wrap-around, so an address near 0xFFFFFFFF is out of range.
REQ-024 An errored request SHALL leave memory unchanged, and SHALL respond with w_err=1 and w_data_out_32=0 after the same LATENCY.
REQ-025 A legal store SHALL write only the addressed 1, 2 or 4 bytes, on the edge entering RESP; all other bytes SHALL be unchanged.
REQ-026 A legal load SHALL read memory on the edge entering RESP, so it sees every earlier completed store.
REQ-027 A legal load SHALL sign- or zero-extend byte and halfword data to 32 bits per the captured w_signed; word loads SHALL ignore w_signed.
REQ-028 w_data_out_32 and w_err SHALL be registered, held stable during RESP, and driven to 0 in every other state.

Reset
REQ-029 While reset=1 on a rising edge, the block SHALL enter IDLE with the counter at 0, w_resp_valid=0, w_err=0, w_data_out_32=0 and w_req_ready=1 in the following cycle.
REQ-030 Reset SHALL NOT clear memory contents; their power-up values are undefined.
REQ-031 Reset asserted during WAIT or RESP SHALL abort the request: a pending store SHALL not be written and no response SHALL be issued.
REQ-032 A request presented in the same cycle as reset=1 SHALL NOT be accepted.

Verification
REQ-033 Store word 0xDEADBEEF at 0x10 with LATENCY=2 -> w_resp_valid high exactly 2 edges after accept, w_err=0; a word load at 0x10 then returns 0xDEADBEEF.
REQ-034 After REQ-033:
- signed byte load at 0x10 -> 0xFFFFFFDE;
- unsigned halfword load at 0x12 -> 0x0000BEEF;
- byte store 0x5A at 0x11, then word load at 0x10 -> 0xDE5ABEEF.
REQ-035 Error cases:
- word store at 0x11 -> w_err=1, w_data_out_32=0, and a word load at 0x10 still returns 0xDEADBEEF;
- word load at MEM_DEPTH-2 -> w_err=1;
- w_size=11 -> w_err=1.
REQ-036 Hold w_req_valid=1 for 10 cycles -> exactly one accept per LATENCY+1 cycles, and w_req_ready=0 throughout WAIT and RESP.
REQ-037 Store 0x11223344 at 0x20, assert reset on the edge after accept -> no w_resp_valid; a later word load at 0x20 returns the prior contents.
REQ-038 Repeat REQ-033 with LATENCY=1 and LATENCY=7 -> response exactly 1 and exactly 7 edges after accept, respectively.
